enc32t5_serial: RTL and testbench
=================================

// Module: enc32t5_serial
// PURPOSE
//  Sequential 32-to-5 priority encoder: the encode side of the 5-to-32 enable decoder.
//  Collects one-hot or multi-hot request bits into a pending set and emits their
//  5-bit indices one at a time, lowest index first, over a valid/ready handshake.
//  Used for register-select and interrupt-line encoding inside the CPU datapath.
// PARAMETERS
//  N_REQ   32  number of request lines; fixed at 32, other values unsupported
//  IDX_W   5   index width; must equal log2(N_REQ)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous active-high reset
//  En         in   1      encode enable; 0 stalls issue of new indices
//  req_i      in   32     request bits, sampled when req_valid=1
//  req_valid  in   1      load strobe; ORs req_i into the pending set
//  idx_o      out  5      encoded index of the presented request
//  idx_valid  out  1      idx_o valid
//  idx_ready  in   1      consumer accepts idx_o when idx_valid=1
//  pending_o  out  32     current pending set
//  none_o     out  1      1 when pending set empty and FSM in IDLE
//  dup_o      out  1      1-cycle pulse: req_valid set a bit already pending
// BEHAVIOUR
//  Reset: pending=0, idx_o=0, idx_valid=0, dup_o=0, none_o=1, FSM=IDLE.
//  rst wins over every other input, including mid-handshake; outstanding idx dropped.
//  Pending update each edge:
//   pending <= (pending & ~clr) | (req_valid ? req_i : 0)
//   clr = one-hot of idx_o when idx_valid & idx_ready, else 0.
//   Same bit cleared and re-requested in one cycle: bit stays set (new request wins).
//  dup_o <= req_valid & |(req_i & pending & ~clr).
//  Selection: lowest set bit of pending (bit0 highest priority); index = bit number.
//  FSM:
//   IDLE : idx_valid=0. -> SEL when En=1 and pending!=0.
//   SEL  : idx_o <= index of lowest set pending bit; -> HOLD. If En=0 -> IDLE.
//   HOLD : idx_valid=1; idx_o stable until accept. En=0 does NOT drop idx_valid.
//          On idx_valid&idx_ready: -> SEL if next pending (after clr, incl. new reqs)
//          !=0 and En=1, else -> IDLE.
//  Latency: req_valid at edge t -> pending visible t+1 -> SEL at t+1 -> idx_valid at t+2
//   (from IDLE, En=1). Throughput: one index per 2 cycles (one SEL bubble per accept).
//  A lower-index request arriving while HOLD does not preempt the presented index;
//   it is chosen at the next SEL.
//  none_o = (pending==0) & (state==IDLE), combinational from registers.
//  idx_o holds its last value when idx_valid=0.
// TESTING
//  1 Single: req_i=32'h0000_0100 strobe, En=1, ready=1 -> idx_o=8 valid at t+2, none_o=1 after.
//  2 Multi: req_i=32'h8000_0011 strobe, ready=1 -> indices 0,4,31 in order, 2 cycles apart.
//  3 Backpressure: req bit 5, ready=0 for 6 cycles -> idx_valid held, idx_o=5 stable;
//    ready=1 -> accepted once, pending_o=0.
//  4 Collision: bit 3 presented and accepted same cycle req_i=bit3 -> pending_o[3]=1,
//    idx_o=3 issued again; dup_o=0. Strobe bit 9 while pending -> dup_o pulse 1 cycle.
//  5 Enable: pending=32'h0000_0006, En=0 -> idx_valid stays 0; En=1 -> idx_o=1 then 2.
//  6 Reset mid-op: rst=1 during HOLD with pending=32'hFFFF_FFFF -> next edge all outputs
//    at reset values, none_o=1.

Source files
------------

// File: rtl/enc32t5_if.sv
// enc32t5_if: request/index handshake bundle for the serial 32-to-5 priority encoder
interface enc32t5_if #(
    parameter int N_REQ = 32,
    parameter int IDX_W = 5
);
    logic             En;
    logic [N_REQ-1:0] req_i;
    logic             req_valid;
    logic [IDX_W-1:0] idx_o;
    logic             idx_valid;
    logic             idx_ready;
    logic [N_REQ-1:0] pending_o;
    logic             none_o;
    logic             dup_o;
    modport master (
        output En, req_i, req_valid, idx_ready,
        input  idx_o, idx_valid, pending_o, none_o, dup_o
    );
    modport slave (
        input  En, req_i, req_valid, idx_ready,
        output idx_o, idx_valid, pending_o, none_o, dup_o
    );
endinterface

// File: rtl/enc32t5_serial.sv
// enc32t5_serial: collects request bits into a pending set and emits their indices lowest-first
module enc32t5_serial (
    input  logic     clk,
    input  logic     rst,
    enc32t5_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEL, HOLD} state_t;
    state_t      state;
    logic [31:0] pending, clr, pending_nxt;
    logic [4:0]  idx, low;
    logic        idx_valid, dup;
    always_comb begin
        clr = (idx_valid && bus.idx_ready) ? 32'd1 << idx : '0;
        pending_nxt = (pending & ~clr) | (bus.req_valid ? bus.req_i : '0);
        low = '0;
        for (int i = 31; i >= 0; i--) low = pending[i] ? 5'(i) : low;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            dup       <= 1'b0;
            state     <= IDLE;
        end else begin
            pending <= pending_nxt;
            dup     <= bus.req_valid & |(bus.req_i & pending & ~clr);
            unique case (state)
                IDLE: if (bus.En && pending != '0) state <= SEL;
                SEL: begin
                    state     <= bus.En ? HOLD : IDLE;
                    idx       <= bus.En ? low : idx;
                    idx_valid <= bus.En;
                end
                // a presented index stays up regardless of En until taken
                HOLD: if (bus.idx_ready) begin
                    idx_valid <= 1'b0;
                    state     <= (bus.En && pending_nxt != '0) ? SEL : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.idx_o     = idx;
    assign bus.idx_valid = idx_valid;
    assign bus.pending_o = pending;
    assign bus.dup_o     = dup;
    assign bus.none_o    = (pending == '0) && (state == IDLE);
endmodule

// File: tb/tb_enc32t5_serial.sv
// tb_enc32t5_serial: directed and random checks of the serial priority encoder against a set-based model
module tb_enc32t5_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    enc32t5_if bus ();
    enc32t5_serial dut (.clk(clk), .rst(rst), .bus(bus));
    int passed = 0;
    int total = 0;
    int cyc = 0;
    logic [31:0] m_pend = '0;
    logic m_dup = 1'b0;
    int issued[$];
    int acc_cyc[$];
    function automatic int lowest(logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic step();
        logic r, pre_v, pre_r;
        logic [4:0] pre_idx;
        logic [31:0] clr, pre_pend;
        r = rst;
        pre_v = bus.idx_valid;
        pre_r = bus.idx_ready;
        pre_idx = bus.idx_o;
        pre_pend = m_pend;
        clr = (pre_v && pre_r) ? (32'd1 << pre_idx) : '0;
        m_dup = bus.req_valid && ((bus.req_i & m_pend & ~clr) != '0);
        m_pend = (m_pend & ~clr) | (bus.req_valid ? bus.req_i : '0);
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            m_pend = '0;
            m_dup = 1'b0;
            return;
        end
        if (pre_v && pre_r) begin
            issued.push_back(int'(pre_idx));
            acc_cyc.push_back(cyc);
        end
        chk("pending", bus.pending_o, m_pend);
        chk("dup", bus.dup_o, m_dup);
        if (bus.none_o) chk("none_empty", m_pend, 0);
        if (!pre_v && bus.idx_valid) chk("sel_idx", bus.idx_o, lowest(pre_pend));
        if (pre_v && !pre_r) begin
            chk("hold_valid", bus.idx_valid, 1);
            chk("hold_idx", bus.idx_o, pre_idx);
        end
    endtask
    task automatic wait_valid(int max);
        int n = 0;
        while (!bus.idx_valid && n < max) begin
            step();
            n++;
        end
        chk("wait_valid", bus.idx_valid, 1);
    endtask
    task automatic drain();
        int n = 0;
        bus.En = 1'b1;
        bus.idx_ready = 1'b1;
        bus.req_valid = 1'b0;
        while (!bus.none_o && n < 80) begin
            step();
            n++;
        end
        chk("drain_none", bus.none_o, 1);
    endtask
    initial begin
        int n0;
        bus.En = 1'b0;
        bus.req_i = '0;
        bus.req_valid = 1'b0;
        bus.idx_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_idx", bus.idx_o, 0);
        chk("rst_valid", bus.idx_valid, 0);
        chk("rst_none", bus.none_o, 1);
        chk("rst_pend", bus.pending_o, 0);
        chk("rst_dup", bus.dup_o, 0);
        // single request, two-cycle latency
        bus.En = 1'b1;
        bus.idx_ready = 1'b1;
        bus.req_i = 32'h0000_0100;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("t1_valid_t1", bus.idx_valid, 0);
        step();
        chk("t1_valid_t2", bus.idx_valid, 1);
        chk("t1_idx", bus.idx_o, 8);
        step();
        chk("t1_none", bus.none_o, 1);
        // multi-hot, lowest first, one per two cycles
        issued.delete();
        acc_cyc.delete();
        bus.req_i = 32'h8000_0011;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && issued.size() < 3; i++) step();
        chk("t2_count", issued.size(), 3);
        if (issued.size() == 3) begin
            chk("t2_first", issued[0], 0);
            chk("t2_second", issued[1], 4);
            chk("t2_third", issued[2], 31);
            chk("t2_gap1", acc_cyc[1] - acc_cyc[0], 2);
            chk("t2_gap2", acc_cyc[2] - acc_cyc[1], 2);
        end
        drain();
        // backpressure
        issued.delete();
        bus.idx_ready = 1'b0;
        bus.req_i = 32'h0000_0020;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        wait_valid(10);
        repeat (6) step();
        chk("t3_valid", bus.idx_valid, 1);
        chk("t3_idx", bus.idx_o, 5);
        n0 = issued.size();
        bus.idx_ready = 1'b1;
        step();
        chk("t3_pend", bus.pending_o, 0);
        step();
        step();
        chk("t3_once", issued.size(), n0 + 1);
        drain();
        // clear and re-request of the same bit, then duplicate strobe
        bus.req_i = 32'h0000_0008;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        wait_valid(10);
        chk("t4_idx", bus.idx_o, 3);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        chk("t4_keep", bus.pending_o[3], 1);
        chk("t4_nodup", bus.dup_o, 0);
        wait_valid(10);
        chk("t4_again", bus.idx_o, 3);
        bus.idx_ready = 1'b0;
        bus.req_i = 32'h0000_0200;
        bus.req_valid = 1'b1;
        step();
        chk("t4_dup_first", bus.dup_o, 0);
        step();
        chk("t4_dup_pulse", bus.dup_o, 1);
        bus.req_valid = 1'b0;
        step();
        chk("t4_dup_end", bus.dup_o, 0);
        drain();
        // enable gating
        issued.delete();
        bus.En = 1'b0;
        bus.req_i = 32'h0000_0006;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        repeat (4) step();
        chk("t5_stall", bus.idx_valid, 0);
        chk("t5_pend", bus.pending_o, 32'h6);
        chk("t5_not_none", bus.none_o, 0);
        bus.En = 1'b1;
        repeat (8) step();
        chk("t5_count", issued.size(), 2);
        if (issued.size() == 2) begin
            chk("t5_first", issued[0], 1);
            chk("t5_second", issued[1], 2);
        end
        // reset during HOLD
        bus.idx_ready = 1'b0;
        bus.req_i = 32'hFFFF_FFFF;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        wait_valid(10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_idx", bus.idx_o, 0);
        chk("t6_valid", bus.idx_valid, 0);
        chk("t6_pend", bus.pending_o, 0);
        chk("t6_dup", bus.dup_o, 0);
        chk("t6_none", bus.none_o, 1);
        // random traffic
        issued.delete();
        for (int i = 0; i < 400; i++) begin
            bus.En = ($urandom_range(0, 7) != 0);
            bus.req_valid = ($urandom_range(0, 3) == 0);
            bus.req_i = $urandom() & $urandom() & $urandom();
            bus.idx_ready = $urandom_range(0, 1) == 1;
            step();
        end
        total++;
        assert (issued.size() > 0) passed++;
        else $error("FAIL rand_issued: observed %0d expected >0", issued.size());
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
